// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: stores A and B, then streams skewed rows/columns.
// Optional FEEDER_TRANSPOSE_B_EN stores B writes transposed so the array computes A * B^T.
module systolic_feeder #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int AW    = 2,
    parameter int FLUSH = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic           wr_mat,
    input  logic [AW-1:0]  wr_row,
    input  logic [AW-1:0]  wr_col,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic [N*W-1:0] a_out,
    output logic [N*W-1:0] b_out,
    output logic           valid,
    output logic           busy,
    output logic           done
);

    localparam int CMAX = (2*N-1 > FLUSH) ? 2*N-1 : FLUSH;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BEAT  = CW'(2*N - 2);
    localparam logic [CW-1:0] LAST_FLUSH = CW'((FLUSH > 0) ? FLUSH - 1 : 0);
    localparam logic [AW:0]   N_LIM      = (AW+1)'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           ended, ended_nxt;
    logic [N*W-1:0] a_nxt, b_nxt;
    logic           valid_nxt, busy_nxt, done_nxt;
    logic           wr_ok;

    logic [W-1:0] a_mem [N][N];
    logic [W-1:0] b_mem [N][N];

    assign wr_ok = wr_en && (state == S_IDLE)
                 && ({1'b0, wr_row} < N_LIM) && ({1'b0, wr_col} < N_LIM);

    // Matrix storage has no reset so that operands survive a reset between runs.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (!wr_mat) begin
                a_mem[IW'(wr_row)][IW'(wr_col)] <= wr_data;
            end else begin
`ifdef FEEDER_TRANSPOSE_B_EN
                b_mem[IW'(wr_col)][IW'(wr_row)] <= wr_data;
`else
                b_mem[IW'(wr_row)][IW'(wr_col)] <= wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ended <= 1'b0;
            a_out <= '0;
            b_out <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ended <= ended_nxt;
            a_out <= a_nxt;
            b_out <= b_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Outputs are computed from the current state and registered, so the visible
    // stream lags the internal state by one cycle; 'ended' marks the IDLE cycle that reports done.
    always_comb begin
        int d;
        logic [IW-1:0] row_i, col_i;
        state_nxt = state;
        cnt_nxt   = cnt;
        ended_nxt = 1'b0;
        a_nxt     = '0;
        b_nxt     = '0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        d         = 0;
        row_i     = '0;
        col_i     = '0;
        case (state)
            S_IDLE: begin
                done_nxt = ended;
                if (start) begin
                    state_nxt = S_STREAM;
                    cnt_nxt   = '0;
                end
            end
            S_STREAM: begin
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
                for (int i = 0; i < N; i++) begin
                    d = int'(cnt) - i;
                    if (d >= 0 && d < N) begin
                        row_i = IW'(i);
                        col_i = IW'(d);
                        a_nxt[i*W +: W] = a_mem[row_i][col_i];
                        b_nxt[i*W +: W] = b_mem[col_i][row_i];
                    end
                end
                if (cnt == LAST_BEAT) begin
                    cnt_nxt = '0;
                    if (FLUSH == 0) begin
                        state_nxt = S_IDLE;
                        ended_nxt = 1'b1;
                    end else begin
                        state_nxt = S_FLUSH;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_FLUSH: begin
                busy_nxt = 1'b1;
                if (cnt == LAST_FLUSH) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                    ended_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
